// File: rtl/caracter_pkg.sv
// Shared geometry constants and the glyph table for the text overlay.
package caracter_pkg;

  localparam int unsigned WIN_W      = 32;
  localparam int unsigned WIN_H      = 64;
  localparam int unsigned GLYPH_W    = 8;
  localparam int unsigned GLYPH_ROWS = 16;
  localparam int unsigned N_CHARS    = 4;

  localparam int unsigned XW   = $clog2(WIN_W);
  localparam int unsigned YW   = $clog2(WIN_H);
  localparam int unsigned CW   = $clog2(N_CHARS);
  localparam int unsigned RW   = $clog2(GLYPH_ROWS);
  localparam int unsigned ROMW = CW + RW;

  // Displayed word "HOLA"; bit 7 of each row is the leftmost pixel.
  localparam logic [7:0] FONT [N_CHARS][GLYPH_ROWS] = '{
    '{8'h81, 8'hC3, 8'hC3, 8'hC3, 8'hC3, 8'hC3, 8'hC3, 8'hFF,
      8'hFF, 8'hC3, 8'hC3, 8'hC3, 8'hC3, 8'hC3, 8'hC3, 8'h81},
    '{8'h3C, 8'h7E, 8'hE7, 8'hC3, 8'hC3, 8'hC3, 8'hC3, 8'hC3,
      8'hC3, 8'hC3, 8'hC3, 8'hC3, 8'hC3, 8'hE7, 8'h7E, 8'h3C},
    '{8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0,
      8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hFE, 8'hFF},
    '{8'h18, 8'h3C, 8'h66, 8'h66, 8'hC3, 8'hC3, 8'hC3, 8'hFF,
      8'hFF, 8'hC3, 8'hC3, 8'hC3, 8'hC3, 8'hC3, 8'hC3, 8'h42}
  };

endpackage

// File: rtl/caracter_rom.sv
// Combinational 64x8 glyph ROM addressed by {char, glyph_row}.
module caracter_rom
  import caracter_pkg::*;
(
  input  logic [ROMW-1:0] addr,
  output logic [7:0]      row_c
);

  // Split the address into glyph index and row within the glyph.
  always_comb begin
    row_c = FONT[addr[ROMW-1:RW]][addr[RW-1:0]];
  end

endmodule

// File: rtl/caracter.sv
// Text-overlay character generator: window decode, offset math and output registers.
module caracter
  import caracter_pkg::*;
#(
  parameter int unsigned X0 = 303,
  parameter int unsigned Y0 = 230
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        video_on,
  input  logic [9:0]  pixel_x,
  input  logic [9:0]  pixel_y,
  output logic [1:0]  char,
  output logic [5:0]  rowad,
  output logic [7:0]  palabra
);

  localparam logic [9:0] X_LO = 10'(X0);
  localparam logic [9:0] X_HI = 10'(X0 + WIN_W - 1);
  localparam logic [9:0] Y_LO = 10'(Y0);
  localparam logic [9:0] Y_HI = 10'(Y0 + WIN_H - 1);
  localparam int unsigned GSH = $clog2(GLYPH_W);
  localparam int unsigned VSC = YW - RW;

  logic            in_win;
  logic [XW-1:0]   dx;
  logic [YW-1:0]   dy;
  logic [CW-1:0]   cidx;
  logic [7:0]      rom_row_c;

  // Window hit and in-window offsets; low bits of the difference suffice since the window is a power of two.
  always_comb begin
    in_win = video_on
           & (pixel_x >= X_LO) & (pixel_x <= X_HI)
           & (pixel_y >= Y_LO) & (pixel_y <= Y_HI);
    dx     = pixel_x[XW-1:0] - X_LO[XW-1:0];
    dy     = pixel_y[YW-1:0] - Y_LO[YW-1:0];
    cidx   = dx[XW-1:GSH];
  end

  caracter_rom u_rom (
    .addr  ({cidx, dy[YW-1:VSC]}),
    .row_c (rom_row_c)
  );

  // Register the decoded outputs; outside the window everything is forced to zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      char    <= 2'b00;
      rowad   <= 6'd0;
      palabra <= 8'h00;
    end else if (in_win) begin
      char    <= cidx;
      rowad   <= dy;
      palabra <= rom_row_c;
    end else begin
      char    <= 2'b00;
      rowad   <= 6'd0;
      palabra <= 8'h00;
    end
  end

endmodule

// File: tb/tb_caracter.sv
// Self-checking bench for the caracter text-overlay generator.
module tb_caracter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       video_on = 1'b0;
  logic [9:0] pixel_x = 10'd0;
  logic [9:0] pixel_y = 10'd0;
  logic [1:0] char;
  logic [5:0] rowad;
  logic [7:0] palabra;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] font_m [4][16] = '{
    '{8'h81, 8'hC3, 8'hC3, 8'hC3, 8'hC3, 8'hC3, 8'hC3, 8'hFF,
      8'hFF, 8'hC3, 8'hC3, 8'hC3, 8'hC3, 8'hC3, 8'hC3, 8'h81},
    '{8'h3C, 8'h7E, 8'hE7, 8'hC3, 8'hC3, 8'hC3, 8'hC3, 8'hC3,
      8'hC3, 8'hC3, 8'hC3, 8'hC3, 8'hC3, 8'hE7, 8'h7E, 8'h3C},
    '{8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0,
      8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hFE, 8'hFF},
    '{8'h18, 8'h3C, 8'h66, 8'h66, 8'hC3, 8'hC3, 8'hC3, 8'hFF,
      8'hFF, 8'hC3, 8'hC3, 8'hC3, 8'hC3, 8'hC3, 8'hC3, 8'h42}
  };

  caracter #(.X0(303), .Y0(230)) dut (
    .clk      (clk),
    .rst      (rst),
    .video_on (video_on),
    .pixel_x  (pixel_x),
    .pixel_y  (pixel_y),
    .char     (char),
    .rowad    (rowad),
    .palabra  (palabra)
  );

  always #5 clk = ~clk;

  // Reference: {char, rowad, palabra} expected one cycle after (x, y, v) is presented.
  function automatic logic [15:0] model(int x, int y, bit v);
    int c, r;
    if (!v || x < 303 || x > 303 + 31 || y < 230 || y > 230 + 63)
      return 16'h0000;
    c = (x - 303) / 8;
    r = y - 230;
    return {2'(c), 6'(r), font_m[c][r / 4]};
  endfunction

  // Present one pixel and move to just after the edge that captures it.
  task automatic drive(int x, int y, bit v);
    pixel_x  = 10'(x);
    pixel_y  = 10'(y);
    video_on = v;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [15:0] exp;
    pixel_x = 10'd303; pixel_y = 10'd230; video_on = 1'b1;
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({char, rowad, palabra} !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_hold got=%h exp=0000", {char, rowad, palabra});
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    exp = model(303, 230, 1'b1);
    n_checks++;
    if ({char, rowad, palabra} !== exp) begin
      n_fail++;
      $display("FAIL reset_release got=%h exp=%h", {char, rowad, palabra}, exp);
    end
  endtask

  task automatic test_hsweep();
    logic [15:0] exp;
    for (int x = 300; x <= 340; x++) begin
      drive(x, 230, 1'b1);
      exp = model(x, 230, 1'b1);
      n_checks++;
      if ({char, rowad, palabra} !== exp) begin
        n_fail++;
        $display("FAIL hsweep x=%0d got=%h exp=%h", x, {char, rowad, palabra}, exp);
      end
    end
  endtask

  task automatic test_lag();
    logic [15:0] exp;
    // Half a cycle after presenting a new pixel the outputs must still show the previous one.
    drive(311, 231, 1'b1);
    pixel_x = 10'd327; pixel_y = 10'd290;
    #3;
    exp = model(311, 231, 1'b1);
    n_checks++;
    if ({char, rowad, palabra} !== exp) begin
      n_fail++;
      $display("FAIL lag_hold got=%h exp=%h", {char, rowad, palabra}, exp);
    end
    @(posedge clk);
    #1;
    exp = model(327, 290, 1'b1);
    n_checks++;
    if ({char, rowad, palabra} !== exp) begin
      n_fail++;
      $display("FAIL lag_update got=%h exp=%h", {char, rowad, palabra}, exp);
    end
  endtask

  task automatic test_vstep();
    logic [15:0] exp;
    for (int y = 230; y <= 294; y++) begin
      for (int x = 303; x <= 334; x++) begin
        drive(x, y, 1'b1);
        exp = model(x, y, 1'b1);
        n_checks++;
        if ({char, rowad, palabra} !== exp) begin
          n_fail++;
          $display("FAIL vstep x=%0d y=%0d got=%h exp=%h", x, y, {char, rowad, palabra}, exp);
        end
      end
    end
  endtask

  task automatic test_video_on();
    logic [15:0] exp;
    drive(315, 240, 1'b0);
    n_checks++;
    if ({char, rowad, palabra} !== 16'h0000) begin
      n_fail++;
      $display("FAIL video_off got=%h exp=0000", {char, rowad, palabra});
    end
    drive(315, 240, 1'b1);
    exp = {2'd1, 6'd10, font_m[1][2]};
    n_checks++;
    if ({char, rowad, palabra} !== exp) begin
      n_fail++;
      $display("FAIL video_restore got=%h exp=%h", {char, rowad, palabra}, exp);
    end
  endtask

  task automatic test_corners();
    int pts [6][2] = '{'{302, 230}, '{335, 230}, '{303, 229}, '{303, 294},
                       '{334, 293}, '{303, 293}};
    logic [15:0] exp;
    for (int i = 0; i < 6; i++) begin
      drive(pts[i][0], pts[i][1], 1'b1);
      exp = model(pts[i][0], pts[i][1], 1'b1);
      n_checks++;
      if ({char, rowad, palabra} !== exp) begin
        n_fail++;
        $display("FAIL corner x=%0d y=%0d got=%h exp=%h", pts[i][0], pts[i][1],
                 {char, rowad, palabra}, exp);
      end
    end
    drive(334, 293, 1'b1);
    exp = {2'd3, 6'd63, font_m[3][15]};
    n_checks++;
    if ({char, rowad, palabra} !== exp) begin
      n_fail++;
      $display("FAIL corner_br got=%h exp=%h", {char, rowad, palabra}, exp);
    end
  endtask

  task automatic test_random();
    logic [15:0] exp;
    int x, y;
    bit v;
    for (int i = 0; i < 600; i++) begin
      x = int'($urandom_range(350, 290));
      y = int'($urandom_range(300, 222));
      v = ($urandom_range(7, 0) != 0);
      drive(x, y, v);
      exp = model(x, y, v);
      n_checks++;
      if ({char, rowad, palabra} !== exp) begin
        n_fail++;
        $display("FAIL random x=%0d y=%0d v=%0d got=%h exp=%h", x, y, v,
                 {char, rowad, palabra}, exp);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [15:0] exp;
    drive(320, 240, 1'b1);
    exp = model(320, 240, 1'b1);
    n_checks++;
    if ({char, rowad, palabra} !== exp) begin
      n_fail++;
      $display("FAIL arst_pre got=%h exp=%h", {char, rowad, palabra}, exp);
    end
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if ({char, rowad, palabra} !== 16'h0000) begin
      n_fail++;
      $display("FAIL arst_immediate got=%h exp=0000", {char, rowad, palabra});
    end
    @(posedge clk);
    #1;
    n_checks++;
    if ({char, rowad, palabra} !== 16'h0000) begin
      n_fail++;
      $display("FAIL arst_held got=%h exp=0000", {char, rowad, palabra});
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if ({char, rowad, palabra} !== exp) begin
      n_fail++;
      $display("FAIL arst_recover got=%h exp=%h", {char, rowad, palabra}, exp);
    end
  endtask

  initial begin
    test_reset();
    test_hsweep();
    test_lag();
    test_vstep();
    test_video_on();
    test_corners();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/caracter.md
# caracter

Text-overlay character generator for the VGA pipeline. It watches the pixel scan coordinates and detects a fixed 32×64-pixel text window holding a 4-character word. Inside the window it outputs the character index, the font row address, and the 8-bit font row bitmap for the pixel-colour stage downstream. Glyph bitmaps come from an internal ROM.

## Interface
Parameters:
- X0, 303, left column of the text window (first pixel inside).
- Y0, 230, top row of the text window.

Ports:
- clk  in  1  pixel/system clock; all state updates on the rising edge.
- rst  in  1  reset. Asynchronous, active-low: rst=0 forces the reset state immediately.
- video_on  in  1  high while the scan is in the visible area.
- pixel_x  in  10  current scan column.
- pixel_y  in  10  current scan row.
- char  out  2  index of the character under the pixel, 0..3, left to right.
- rowad  out  6  font row address inside the window, 0..63.
- palabra  out  8  font row bitmap of the current character; bit 7 is the leftmost pixel.

## Operation
- The window is X0 ≤ pixel_x ≤ X0+31 and Y0 ≤ pixel_y ≤ Y0+63. Compare in 10-bit unsigned arithmetic with no wrap; X0+31 and Y0+63 must each be ≤ 1023.
- in_win = video_on & window hit.
- dx = pixel_x − X0 (5 bits used) and dy = pixel_y − Y0 (6 bits used).
- When in_win:
  - char = dx[4:3], so each glyph is 8 pixels wide.
  - rowad = dy[5:0].
  - palabra = FONT[char][dy[5:2]]. Glyphs are 8×16 and each row is repeated on 4 scan lines (×4 vertical scale).
- When not in_win: char=0, rowad=0, palabra=8'h00. This gives a blank output, and the pixel stage treats all-zero as transparent.
- Edges (left/right, top/bottom) are inclusive:
  - pixel_x = X0−1 or X0+32 is outside.
  - pixel_y = Y0+64 is outside.
- A video_on drop mid-window forces the zero outputs on the next edge.
- The block has no FSM. It is a pure registered combinational map.

## Timing
- Outputs are registered with a latency of 1 clock from pixel_x/pixel_y/video_on to char/rowad/palabra.
- Reset value of every output is 0: char=2'b00, rowad=6'd0, palabra=8'h00.
- Reset is asserted asynchronously. Release takes effect on the first rising edge with rst=1.
- Asserting reset mid-window clears the outputs immediately. After release, outputs resume from the current coordinates after the 1-cycle latency.
- Inputs may change on every cycle. The block has no handshake and no back-pressure.

## Structure
- Shared package caracter_pkg holds:
  - WIN_W=32, WIN_H=64, GLYPH_W=8, GLYPH_ROWS=16, N_CHARS=4.
  - The FONT constant: 4 glyphs × 16 rows × 8 bits, which defines the displayed word.
- Sub-module caracter_rom is a synchronous-read or combinational 64×8 ROM addressed by {char, dy[5:2]}.
  - If the ROM read is synchronous, the top level must keep the total latency at exactly 1 cycle. It does this by registering the window decode in parallel with the ROM read, not after it.
- The top level contains the window compare, the subtraction, and the output registers.

## Test plan
- Reset: hold rst=0 with in-window coordinates (x=303, y=230) → char=0, rowad=0, palabra=0. Release rst → one edge later char=0, rowad=0, palabra=FONT[0][0].
- Horizontal sweep at y=230, x from 300 to 340, one step per clock:
  - x=300..302 and x≥335 give all-zero.
  - x=303..310 give char=0, x=311..318 give char=1, x=319..326 give char=2, x=327..334 give char=3.
  - palabra=FONT[char][0] in each window range.
  - Every output lags its input by 1 cycle.
- Vertical stepping: repeat 32-pixel scans while incrementing y once per scan from 230 to 294.
  - rowad tracks y−230, 0..63.
  - palabra changes glyph row every 4 lines: y=234 gives FONT[c][1] and y=293 gives FONT[c][15].
  - y=294 gives all-zero.
- video_on=0 at x=315, y=240 → all-zero next cycle. Restoring video_on=1 → char=1, rowad=10, palabra=FONT[1][2].
- Corner boundaries:
  - (302,230), (335,230), (303,229) and (303,294) give zero.
  - (334,293) gives char=3, rowad=63, palabra=FONT[3][15].
- Mid-window async reset at x=320: outputs clear without waiting for a clock edge. Recovery occurs on the first edge after release.
